// File: rtl/afe_spi_pkg.sv
// afe_spi_pkg: shared constants and types for the AFE SPI responder.
//   AFE_SPI_WORD_WIDTH   default bits per SPI word
//   AFE_SPI_SYNC_STAGES  default synchronizer depth
//   afe_spi_cnt_width()  width needed to count 0..WORD_WIDTH+1 bits
//   bit_count_t          bit counter type at the default word width
package afe_spi_pkg;

   localparam int unsigned AFE_SPI_WORD_WIDTH  = 24;
   localparam int unsigned AFE_SPI_SYNC_STAGES = 2;

   // The counter must hold WORD_WIDTH+1 so an over-long word is distinguishable.
   function automatic int unsigned afe_spi_cnt_width(input int unsigned word_width);
      return $clog2(word_width + 2);
   endfunction

   typedef logic [$clog2(AFE_SPI_WORD_WIDTH + 2)-1:0] bit_count_t;

endpackage

// File: rtl/spi_input_sync.sv
// spi_input_sync: multi-stage synchronizer for one asynchronous SPI input, followed by a
// history register and registered edge detection.
// Ports:
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   din_i    asynchronous input
//   level_o  synchronized level, aligned with rise_o/fall_o
//   rise_o   one-cycle pulse on a synchronized rising edge
//   fall_o   one-cycle pulse on a synchronized falling edge
module spi_input_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic din_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              hist_q;
   logic              rise_q;
   logic              fall_q;

   // History resets to 0, so an input already high at reset release yields one rise.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
         hist_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din_i};
         hist_q <= sync_q[STAGES-1];
         rise_q <= sync_q[STAGES-1] & ~hist_q;
         fall_q <= ~sync_q[STAGES-1] & hist_q;
      end
   end

   // hist_q updates on the same edge as rise_q/fall_q, so level and edges line up.
   assign level_o = hist_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/afe_spi_responder.sv
// afe_spi_responder: oversampled SPI write responder for an AFE. Shifts spiSdi in on
// synchronized spiClk rising edges while spiLe is low and judges the word on the spiLe
// rising edge: correct length updates wordData, any other length pulses lengthErr.
// Optional feature macro: AFE_SPI_RESPONDER_READBACK_EN adds a readback shift register
// driving spiSdo; without it spiSdo is tied low.
// Ports:
//   sysClk, sysResetN     system clock, asynchronous active-low reset
//   spiClk, spiSdi, spiLe asynchronous SPI inputs (MSB first, latch on spiLe rise)
//   spiSdo                readback data
//   wordData, wordValid   last correct-length word and its one-cycle update pulse
//   lengthErr, errCount   wrong-length pulse and saturating error count
//   busy                  a word is being shifted in
module afe_spi_responder
   import afe_spi_pkg::*;
#(
   parameter int unsigned WORD_WIDTH   = AFE_SPI_WORD_WIDTH,
   parameter int unsigned SYNC_STAGES  = AFE_SPI_SYNC_STAGES,
   parameter int unsigned ERRCNT_WIDTH = 16
) (
   input  logic                    sysClk,
   input  logic                    sysResetN,
   input  logic                    spiClk,
   input  logic                    spiSdi,
   input  logic                    spiLe,
   output logic                    spiSdo,
   output logic [WORD_WIDTH-1:0]   wordData,
   output logic                    wordValid,
   output logic                    lengthErr,
   output logic [ERRCNT_WIDTH-1:0] errCount,
   output logic                    busy
);

   localparam int unsigned     CntW    = afe_spi_cnt_width(WORD_WIDTH);
   localparam logic [CntW-1:0] FullCnt = CntW'(WORD_WIDTH);
   localparam logic [CntW-1:0] MaxCnt  = CntW'(WORD_WIDTH + 1);

   logic clk_level, clk_rise, clk_fall;
   logic le_level, le_rise, le_fall;
   logic sdi_level, sdi_rise, sdi_fall;

   spi_input_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
      .clk_i  (sysClk),
      .rst_ni (sysResetN),
      .din_i  (spiClk),
      .level_o(clk_level),
      .rise_o (clk_rise),
      .fall_o (clk_fall)
   );

   spi_input_sync #(.STAGES(SYNC_STAGES)) u_sync_le (
      .clk_i  (sysClk),
      .rst_ni (sysResetN),
      .din_i  (spiLe),
      .level_o(le_level),
      .rise_o (le_rise),
      .fall_o (le_fall)
   );

   spi_input_sync #(.STAGES(SYNC_STAGES)) u_sync_sdi (
      .clk_i  (sysClk),
      .rst_ni (sysResetN),
      .din_i  (spiSdi),
      .level_o(sdi_level),
      .rise_o (sdi_rise),
      .fall_o (sdi_fall)
   );

   logic [WORD_WIDTH-1:0]   shift_q, shift_d;
   logic [CntW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [WORD_WIDTH-1:0]   word_q, word_d;
   logic                    valid_q, valid_d;
   logic                    err_q, err_d;
   logic [ERRCNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

   // A latch edge takes priority; le_level is already high then, so a coincident
   // clock edge is dropped and the latch judges the prior bit count.
   always_comb begin
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      word_d    = word_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      err_cnt_d = err_cnt_q;
      if (le_rise) begin
         bit_cnt_d = '0;
         if (bit_cnt_q == FullCnt) begin
            word_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            err_d = 1'b1;
            if (err_cnt_q != '1) begin
               err_cnt_d = err_cnt_q + ERRCNT_WIDTH'(1);
            end
         end
      end else if (clk_rise && !le_level) begin
         shift_d = {shift_q[WORD_WIDTH-2:0], sdi_level};
         if (bit_cnt_q != MaxCnt) begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge sysClk or negedge sysResetN) begin
      if (!sysResetN) begin
         shift_q   <= '0;
         bit_cnt_q <= '0;
         word_q    <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         word_q    <= word_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign wordData  = word_q;
   assign wordValid = valid_q;
   assign lengthErr = err_q;
   assign errCount  = err_cnt_q;
   assign busy      = ~le_level & (bit_cnt_q != '0);

`ifdef AFE_SPI_RESPONDER_READBACK_EN
   logic [WORD_WIDTH-1:0] rb_q, rb_d;

   // Reload on each accepted word, then present it MSB first on falling SPI edges.
   always_comb begin
      rb_d = rb_q;
      if (valid_q) begin
         rb_d = word_q;
      end else if (clk_fall && !le_level) begin
         rb_d = {rb_q[WORD_WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge sysClk or negedge sysResetN) begin
      if (!sysResetN) begin
         rb_q <= '0;
      end else begin
         rb_q <= rb_d;
      end
   end

   assign spiSdo = rb_q[WORD_WIDTH-1];

   logic unused_edges;
   assign unused_edges = ^{clk_level, le_fall, sdi_rise, sdi_fall};
`else
   assign spiSdo = 1'b0;

   logic unused_edges;
   assign unused_edges = ^{clk_level, clk_fall, le_fall, sdi_rise, sdi_fall};
`endif

endmodule

// File: tb/tb_afe_spi_responder.sv
// tb_afe_spi_responder: self-checking bench for afe_spi_responder. A second instance with a
// 3-bit error counter shares the stimulus so counter saturation is reached quickly.
// Honours AFE_SPI_RESPONDER_READBACK_EN for the spiSdo checks.
module tb_afe_spi_responder;

   localparam int W       = 24;
   localparam int LATENCY = 4;  // SYNC_STAGES + 2 at the default depth

   logic sysClk    = 1'b0;
   logic sysResetN = 1'b0;
   logic spiClk    = 1'b0;
   logic spiSdi    = 1'b0;
   logic spiLe     = 1'b0;

   logic          spiSdo;
   logic [W-1:0]  wordData;
   logic          wordValid;
   logic          lengthErr;
   logic [15:0]   errCount;
   logic          busy;

   logic          s_sdo;
   logic [W-1:0]  s_word;
   logic          s_valid;
   logic          s_err;
   logic [2:0]    s_cnt;
   logic          s_busy;

   afe_spi_responder dut (
      .sysClk   (sysClk),
      .sysResetN(sysResetN),
      .spiClk   (spiClk),
      .spiSdi   (spiSdi),
      .spiLe    (spiLe),
      .spiSdo   (spiSdo),
      .wordData (wordData),
      .wordValid(wordValid),
      .lengthErr(lengthErr),
      .errCount (errCount),
      .busy     (busy)
   );

   afe_spi_responder #(.ERRCNT_WIDTH(3)) dut_small (
      .sysClk   (sysClk),
      .sysResetN(sysResetN),
      .spiClk   (spiClk),
      .spiSdi   (spiSdi),
      .spiLe    (spiLe),
      .spiSdo   (s_sdo),
      .wordData (s_word),
      .wordValid(s_valid),
      .lengthErr(s_err),
      .errCount (s_cnt),
      .busy     (s_busy)
   );

   always #5 sysClk = ~sysClk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge sysClk);
   endtask

   function automatic logic [63:0] all_outputs();
      return {20'd0, wordData, wordValid, lengthErr, errCount, busy, spiSdo};
   endfunction

   // Bit period of 10 sysClk; spiSdo captured just before each falling edge.
   task automatic send_bits(input logic [31:0] data, input int n, output logic [W-1:0] cap);
      cap = '0;
      for (int i = n - 1; i >= 0; i--) begin
         spiSdi = data[i];
         spiClk = 1'b0;
         wait_neg(5);
         spiClk = 1'b1;
         wait_neg(5);
         if (i == n - 1) check("busy_shifting", busy, 1);
         cap = {cap[W-2:0], spiSdo};
      end
      spiClk = 1'b0;
      wait_neg(5);
   endtask

   // Called right after spiLe rises (or reset releases with spiLe high) on a negedge.
   task automatic observe(input string name, input bit exp_valid, input logic [W-1:0] exp_word,
                          input int exp_err);
      int nv, ne, both, lat;
      nv = 0; ne = 0; both = 0; lat = -1;
      for (int k = 1; k <= 12; k++) begin
         @(posedge sysClk);
         #1;
         if (wordValid) nv++;
         if (lengthErr) ne++;
         if (wordValid && lengthErr) both++;
         if ((wordValid || lengthErr) && lat < 0) lat = k;
      end
      check({name, " valid_pulses"}, nv, exp_valid ? 1 : 0);
      check({name, " err_pulses"}, ne, exp_valid ? 0 : 1);
      check({name, " both_high"}, both, 0);
      check({name, " latency"}, lat, LATENCY);
      check({name, " wordData"}, wordData, exp_word);
      check({name, " errCount"}, errCount, exp_err);
      check({name, " errCount_sat3"}, s_cnt, (exp_err > 7) ? 7 : exp_err);
      check({name, " busy_latched"}, busy, 0);
      @(negedge sysClk);
   endtask

   logic [W-1:0] last_cap;

   task automatic run_txn(input string name, input logic [31:0] data, input int n,
                          input bit exp_valid, input logic [W-1:0] exp_word, input int exp_err);
      logic [W-1:0] cap;
      spiLe = 1'b0;
      wait_neg(6);
      send_bits(data, n, cap);
      last_cap = cap;
`ifndef AFE_SPI_RESPONDER_READBACK_EN
      check({name, " spiSdo_zero"}, cap, 0);
`endif
      spiLe = 1'b1;
      observe(name, exp_valid, exp_word, exp_err);
   endtask

   typedef struct {
      logic [31:0]  data;
      int           nbits;
      bit           exp_valid;
      logic [W-1:0] exp_word;
      int           exp_err;
   } vec_t;

   vec_t        vecs[11];
   int          m_err;
   int          m_word;
   int          nb;
   logic [31:0] d;
   bit          exp_v;
   bit          q[$];

   initial begin
      vecs[0]  = '{32'h00A5C3F0, 24, 1'b1, 24'hA5C3F0, 0};
      vecs[1]  = '{32'h007FFFFF, 23, 1'b0, 24'hA5C3F0, 1};
      vecs[2]  = '{32'h03123456, 26, 1'b0, 24'hA5C3F0, 2};
      vecs[3]  = '{32'h00000000,  0, 1'b0, 24'hA5C3F0, 3};
      vecs[4]  = '{32'h01FFFFFF, 25, 1'b0, 24'hA5C3F0, 4};
      vecs[5]  = '{32'h000F0F0F, 24, 1'b1, 24'h0F0F0F, 4};
      vecs[6]  = '{32'h00000001,  1, 1'b0, 24'h0F0F0F, 5};
      vecs[7]  = '{32'h00000ABC, 12, 1'b0, 24'h0F0F0F, 6};
      vecs[8]  = '{32'h05555555, 27, 1'b0, 24'h0F0F0F, 7};
      vecs[9]  = '{32'h3FFFFFFF, 30, 1'b0, 24'h0F0F0F, 8};
      vecs[10] = '{32'h00123456, 24, 1'b1, 24'h123456, 8};

      // Reset state, during and after reset with idle inputs.
      wait_neg(3);
      check("reset_outputs", all_outputs(), 0);
      check("reset_errcnt_sat3", s_cnt, 0);
      sysResetN = 1'b1;
      wait_neg(4);
      check("post_reset_outputs", all_outputs(), 0);

      foreach (vecs[i]) begin
         run_txn($sformatf("vec%0d", i), vecs[i].data, vecs[i].nbits, vecs[i].exp_valid,
                 vecs[i].exp_word, vecs[i].exp_err);
      end

      // Reset mid-word discards the partial word and the error history.
      spiLe = 1'b0;
      wait_neg(6);
      send_bits(32'h00000FFF, 12, last_cap);
      sysResetN = 1'b0;
      #1;
      check("async_reset_midword", all_outputs(), 0);
      wait_neg(3);
      sysResetN = 1'b1;
      wait_neg(2);
      run_txn("after_reset", 32'h000F0F0F, 24, 1'b1, 24'h0F0F0F, 0);

      // spiLe high through reset release gives exactly one length error.
      sysResetN = 1'b0;
      #1;
      check("async_reset_le_high", all_outputs(), 0);
      wait_neg(3);
      sysResetN = 1'b1;
      observe("le_held_release", 1'b0, 24'h000000, 1);

      // Randomized words against a bit-queue model.
      m_word = 0;
      m_err  = 1;
      for (int t = 0; t < 24; t++) begin
         nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(20, 27)) : 24;
         d  = $urandom;
         q.delete();
         for (int i = nb - 1; i >= 0; i--) q.push_back(d[i]);
         if (q.size() == W) begin
            exp_v  = 1'b1;
            m_word = 0;
            foreach (q[j]) m_word = m_word * 2 + int'(q[j]);
         end else begin
            exp_v = 1'b0;
            if (m_err < 65535) m_err++;
         end
         run_txn($sformatf("rand%0d_n%0d", t, nb), d, nb, exp_v, m_word[W-1:0], m_err);
      end

      // Clock and latch edges together: the clock edge is dropped, so 23 bits remain.
      spiLe = 1'b0;
      wait_neg(6);
      send_bits(32'h00123456, 23, last_cap);
      spiSdi = 1'b1;
      spiClk = 1'b1;
      spiLe  = 1'b1;
      if (m_err < 65535) m_err++;
      observe("coincident_edges", 1'b0, m_word[W-1:0], m_err);
      spiClk = 1'b0;
      wait_neg(5);

      // Readback: a latched 0x800001 appears on spiSdo during the next word.
      run_txn("rb_load", 32'h00800001, 24, 1'b1, 24'h800001, m_err);
      run_txn("rb_read", 32'h00C0FFEE, 24, 1'b1, 24'hC0FFEE, m_err);
`ifdef AFE_SPI_RESPONDER_READBACK_EN
      check("readback_bits", last_cap, 24'h800001);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/afe_spi_responder.md
AFE_SPI_RESPONDER -- requirements
Module: afe_spi_responder

Interface
REQ-001 Parameter WORD_WIDTH, default 24: number of bits per AFE SPI word.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flip-flops on each SPI input (legal range 2..4).
REQ-003 Parameter ERRCNT_WIDTH, default 16: width of the length-error counter.
REQ-004 Port sysClk, input, 1: the block's single clock. All logic SHALL run on this clock.
REQ-005 Port sysResetN, input, 1: asynchronous, active-low reset.
REQ-006 Port spiClk, input, 1: SPI serial clock. It is asynchronous to sysClk.
REQ-007 Port spiSdi, input, 1: SPI serial data, MSB first.
REQ-008 Port spiLe, input, 1: latch enable. Low while shifting; a rising edge latches the word.
REQ-009 Port spiSdo, output, 1: readback serial data. Active only with the readback feature (REQ-030).
REQ-010 Port wordData, output, WORD_WIDTH: the last word latched with the correct length.
REQ-011 Port wordValid, output, 1: one-cycle pulse when wordData updates.
REQ-012 Port lengthErr, output, 1: one-cycle pulse on a latch with the wrong bit count.
REQ-013 Port errCount, output, ERRCNT_WIDTH: saturating count of length errors.
REQ-014 Port busy, output, 1: high while spiLe is low (synchronized) and bitCount > 0.

Function
REQ-015 Each of spiClk, spiSdi and spiLe SHALL pass through a SYNC_STAGES synchronizer, followed by one history register for edge detection.
REQ-016 On a synchronized rising edge of spiClk while synchronized spiLe = 0:
  - shift spiSdi into the LSB of the shift register (shiftReg <= {shiftReg[W-2:0], sdi});
  - increment bitCount, saturating at WORD_WIDTH+1.
REQ-017 spiClk edges SHALL be ignored while synchronized spiLe = 1.
REQ-018 A synchronized rising edge of spiLe with bitCount == WORD_WIDTH SHALL:
  - load wordData <= shiftReg;
  - pulse wordValid high for exactly one cycle.
REQ-019 A synchronized rising edge of spiLe with bitCount != WORD_WIDTH (including 0 and overflow) SHALL:
  - pulse lengthErr for one cycle;
  - leave wordData unchanged;
  - increment errCount, saturating at all-ones.
REQ-020 The rising spiLe edge SHALL clear bitCount to 0 in the same cycle.
REQ-021 If a spiClk rising edge and a spiLe rising edge are detected in the same cycle, the clock edge SHALL be ignored: LE is taken as already high. The latch uses the prior bitCount.
REQ-022 Latency: wordValid/lengthErr SHALL assert on the (SYNC_STAGES+2)th sysClk rising edge after the first edge that samples spiLe = 1.
REQ-023 Input timing: the spiClk high and low times SHALL each be at least SYNC_STAGES+1 sysClk periods. spiSdi and spiLe SHALL be stable for the same time around spiClk rising edges.
REQ-024 wordValid and lengthErr SHALL never be high in the same cycle.

Reset
REQ-025 While sysResetN = 0, the following SHALL be 0 asynchronously: all synchronizers, shiftReg, bitCount, wordData, wordValid, lengthErr, errCount, busy and spiSdo.
REQ-026 Reset asserted mid-word SHALL discard the partial word. After release, the first spiLe rising edge SHALL be judged with bitCount counted from release.
REQ-027 The synchronizer history register SHALL reset to 0, so spiLe held high through reset release produces one edge. With bitCount 0, that edge yields one lengthErr.

Configuration
REQ-028 Macro AFE_SPI_RESPONDER_READBACK_EN, when defined, SHALL add a WORD_WIDTH readback register.
REQ-029 With AFE_SPI_RESPONDER_READBACK_EN, readback behaviour SHALL be:
  - the readback register loads wordData on each wordValid;
  - it shifts left on each synchronized spiClk falling edge while spiLe is low;
  - spiSdo is its registered MSB.
REQ-030 Without AFE_SPI_RESPONDER_READBACK_EN, spiSdo SHALL be a constant 0 and no readback register SHALL exist.

Structure
REQ-031 Package afe_spi_pkg SHALL hold:
  - default constants AFE_SPI_WORD_WIDTH = 24 and AFE_SPI_SYNC_STAGES = 2;
  - a typedef for the bitCount width, $clog2(WORD_WIDTH+2).
REQ-032 One sub-module, spi_input_sync, SHALL implement one synchronizer plus rise/fall edge-detect outputs. It SHALL be instantiated three times.

Verification
REQ-033 LE low, then 24 bits of 0xA5C3F0 MSB-first at a 10-sysClk period, then LE high -> one wordValid pulse, wordData = 0xA5C3F0, errCount = 0.
REQ-034 23 bits, then LE high -> lengthErr pulse, no wordValid, wordData holds its previous value, errCount = 1.
REQ-035 26 bits, where the last 24 are 0x123456 -> lengthErr, errCount increments, wordData unchanged.
REQ-036 Preload errCount to 0xFFFF via repeated short words, then one more short word -> errCount stays 0xFFFF.
REQ-037 Assert sysResetN low after 12 bits, release, send 24 bits 0x0F0F0F, then LE -> wordValid, wordData = 0x0F0F0F. Check that LE held high through release gives exactly one lengthErr.
REQ-038 With AFE_SPI_RESPONDER_READBACK_EN: latch 0x800001, then clock 24 bits -> spiSdo reads 1, twenty-two 0s, then 1 on successive falling edges. Without the macro, spiSdo stays 0.
